// File: rtl/data_mem_if.sv
// Load/store bus between the core (master) and the data-memory responder (slave).
interface data_mem_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        MemReady;
  logic        MemErr;

  modport master (
    output MemRead, MemWrite, DataAdr, WriteData,
    input  ReadData, MemReady, MemErr
  );

  modport slave (
    input  MemRead, MemWrite, DataAdr, WriteData,
    output ReadData, MemReady, MemErr
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data RAM target with programmable wait states and illegal-access rejection.
// MemReady/MemErr pulse the cycle after the FSM sits in RESP; ReadData settles one cycle earlier.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
  input logic        clk,
  input logic        reset,
  data_mem_if.slave  bus
);

  localparam int          IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  CNT_INIT   = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // diff carries a borrow bit so an address below the base can never alias to a low index
  function automatic logic access_ok(input logic [32:0] diff, input logic [1:0] adr_lo,
                                     input logic rd, input logic wr);
    return !diff[32] && (diff[31:0] < SPAN_BYTES) && (adr_lo == 2'b00) && !(rd && wr);
  endfunction

  logic [31:0] mem [DEPTH_WORDS];

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              write_q, write_d;
  logic              bad_q, bad_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;

  logic [32:0]       req_diff;
  logic [IDX_W-1:0]  req_idx;
  logic              req_any;
  logic              req_ok;

  logic              mem_we;
  logic [IDX_W-1:0]  mem_idx;
  logic [31:0]       mem_wdata;

  assign req_diff = {1'b0, bus.DataAdr} - {1'b0, ADDR_BASE};
  assign req_idx  = req_diff[IDX_W+1:2];
  assign req_any  = bus.MemRead | bus.MemWrite;
  assign req_ok   = access_ok(req_diff, bus.DataAdr[1:0], bus.MemRead, bus.MemWrite);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    write_d   = write_q;
    bad_d     = bad_q;
    rdata_d   = rdata_q;
    ready_d   = (state_q == ST_RESP);
    err_d     = (state_q == ST_RESP) && bad_q;
    mem_we    = 1'b0;
    mem_idx   = idx_q;
    mem_wdata = wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (req_any) begin
          idx_d   = req_idx;
          wdata_d = bus.WriteData;
          write_d = bus.MemWrite;
          if (!req_ok) begin
            state_d = ST_RESP;
            bad_d   = 1'b1;
            rdata_d = 32'd0;
          end else if (WAIT_STATES == 0) begin
            // zero-wait commit uses the live inputs since nothing is latched yet
            state_d = ST_RESP;
            bad_d   = 1'b0;
            if (bus.MemWrite) begin
              mem_we    = 1'b1;
              mem_idx   = req_idx;
              mem_wdata = bus.WriteData;
            end else begin
              rdata_d = mem[req_idx];
            end
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
            bad_d   = 1'b0;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
          if (write_q) mem_we  = 1'b1;
          else         rdata_d = mem[idx_q];
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      bad_q   <= 1'b0;
      rdata_q <= 32'd0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      bad_q   <= bad_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    idx_q   <= idx_d;
    wdata_q <= wdata_d;
  end

  // RAM is not reset; the reset gate keeps a zero-wait store from landing while held in reset
  always_ff @(posedge clk) begin
    if (mem_we && reset) mem[mem_idx] <= mem_wdata;
  end

  assign bus.ReadData = rdata_q;
  assign bus.MemReady = ready_q;
  assign bus.MemErr   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: four instances in different configurations, a transaction-level
// timing model checked every cycle, plus literal latency/data expectations per transaction.
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] rst_n;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vec = 0;
  int mis = 0;

  data_mem_if bus0 ();
  data_mem_if bus1 ();
  data_mem_if bus2 ();
  data_mem_if bus3 ();

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2), .ADDR_BASE(32'h0000_0000))
    u_ws2 (.clk(clk), .reset(rst_n[0]), .bus(bus0));
  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0), .ADDR_BASE(32'h0000_0000))
    u_ws0 (.clk(clk), .reset(rst_n[1]), .bus(bus1));
  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2), .ADDR_BASE(32'h0000_1000))
    u_base (.clk(clk), .reset(rst_n[2]), .bus(bus2));
  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(4), .ADDR_BASE(32'h0000_0000))
    u_ws4 (.clk(clk), .reset(rst_n[3]), .bus(bus3));

  logic        rdy_w [4];
  logic        err_w [4];
  logic [31:0] rd_w  [4];
  assign rdy_w[0] = bus0.MemReady; assign err_w[0] = bus0.MemErr; assign rd_w[0] = bus0.ReadData;
  assign rdy_w[1] = bus1.MemReady; assign err_w[1] = bus1.MemErr; assign rd_w[1] = bus1.ReadData;
  assign rdy_w[2] = bus2.MemReady; assign err_w[2] = bus2.MemErr; assign rd_w[2] = bus2.ReadData;
  assign rdy_w[3] = bus3.MemReady; assign err_w[3] = bus3.MemErr; assign rd_w[3] = bus3.ReadData;

  function automatic int ws_of(input int k);
    case (k)
      0: return 2;
      1: return 0;
      2: return 2;
      default: return 4;
    endcase
  endfunction

  function automatic longint base_of(input int k);
    return (k == 2) ? 64'h1000 : 64'h0;
  endfunction

  // Model state: pending response per instance, shadow memory, expected held ReadData
  logic [31:0] mmem     [4][256];
  int          resp_cyc [4];
  bit          pend_err [4];
  bit          pend_we  [4];
  bit          pend_rdu [4];
  int          pend_idx [4];
  logic [31:0] pend_wd  [4];
  logic [31:0] pend_rv  [4];
  logic [31:0] exp_rd   [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    vec++;
    if (act !== exp_v) begin
      mis++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  // Every cycle: ReadData changes on the edge before MemReady; MemReady/MemErr pulse one cycle
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        logic er;
        logic ee;
        er = 1'b0;
        ee = 1'b0;
        if (cyc == resp_cyc[k] - 1) begin
          if (pend_we[k])  mmem[k][pend_idx[k]] = pend_wd[k];
          if (pend_rdu[k]) exp_rd[k] = pend_rv[k];
        end
        if (cyc == resp_cyc[k]) begin
          er = 1'b1;
          ee = pend_err[k];
        end
        chk($sformatf("dut%0d MemReady cyc%0d", k, cyc), 32'(rdy_w[k]), 32'(er));
        chk($sformatf("dut%0d MemErr cyc%0d", k, cyc), 32'(err_w[k]), 32'(ee));
        chk($sformatf("dut%0d ReadData cyc%0d", k, cyc), rd_w[k], exp_rd[k]);
      end
    end
  end

  task automatic set_in(input int k, input logic rd, input logic wr,
                        input logic [31:0] adr, input logic [31:0] wd);
    case (k)
      0: begin bus0.MemRead = rd; bus0.MemWrite = wr; bus0.DataAdr = adr; bus0.WriteData = wd; end
      1: begin bus1.MemRead = rd; bus1.MemWrite = wr; bus1.DataAdr = adr; bus1.WriteData = wd; end
      2: begin bus2.MemRead = rd; bus2.MemWrite = wr; bus2.DataAdr = adr; bus2.WriteData = wd; end
      default: begin bus3.MemRead = rd; bus3.MemWrite = wr; bus3.DataAdr = adr; bus3.WriteData = wd; end
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic txn(input int k, input logic rd, input logic wr, input logic [31:0] adr,
                     input logic [31:0] wd, input bit scramble, input int exp_lat,
                     input bit exp_e, input bit chk_d, input logic [31:0] exp_d, input string nm);
    int     cap;
    int     lat;
    bit     ok;
    bit     got;
    longint d;
    step();
    set_in(k, rd, wr, adr, wd);
    step();
    cap = cyc;
    d   = longint'(adr) - base_of(k);
    ok  = (d >= 0) && (d < 1024) && (adr % 4 == 0) && !(rd && wr);
    resp_cyc[k] = cap + (ok ? ws_of(k) + 1 : 1);
    pend_err[k] = !ok;
    pend_we[k]  = ok && wr;
    pend_idx[k] = ok ? int'(d / 4) : 0;
    pend_wd[k]  = wd;
    pend_rdu[k] = !ok || rd;
    pend_rv[k]  = (ok && rd) ? mmem[k][int'(d / 4)] : 32'd0;
    if (scramble) set_in(k, 1'b0, 1'b0, adr + 32'd4, ~wd);
    else          set_in(k, 1'b0, 1'b0, adr, wd);
    got = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (rdy_w[k] === 1'b1) begin
        got = 1'b1;
        lat = cyc - cap;
        break;
      end
    end
    chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
    if (got) begin
      chk({nm, " MemErr"}, 32'(err_w[k]), 32'(exp_e));
      if (chk_d) chk({nm, " ReadData"}, rd_w[k], exp_d);
    end
  endtask

  // Store capture, then reset pulse in the second WAIT cycle
  task automatic abort_wr(input int k, input logic [31:0] adr, input logic [31:0] wd);
    step();
    set_in(k, 1'b0, 1'b1, adr, wd);
    step();
    set_in(k, 1'b0, 1'b0, adr, wd);
    step();
    resp_cyc[k] = -1;
    exp_rd[k]   = 32'd0;
    rst_n[k]    = 1'b0;
    step();
    rst_n[k]    = 1'b1;
    repeat (8) step();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 4'hF;
    for (int k = 0; k < 4; k++) begin
      resp_cyc[k] = -1;
      exp_rd[k]   = 32'd0;
      set_in(k, 1'b0, 1'b0, 32'd0, 32'd0);
    end
    #1 rst_n = 4'h0;
    repeat (3) step();
    rst_n = 4'hF;
    repeat (2) step();

    // Default configuration: store then load
    txn(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 3, 1'b0, 1'b0, 32'd0, "t1 store 0x10");
    txn(0, 1'b1, 1'b0, 32'h10, 32'd0, 1'b0, 3, 1'b0, 1'b1, 32'hDEADBEEF, "t1 load 0x10");

    // Illegal requests answer after one cycle with ReadData cleared
    txn(0, 1'b0, 1'b1, 32'h8, 32'h0BADF00D, 1'b0, 3, 1'b0, 1'b0, 32'd0, "t3 store 0x8");
    txn(0, 1'b1, 1'b0, 32'h2, 32'd0, 1'b0, 1, 1'b1, 1'b1, 32'd0, "t3 misaligned");
    txn(0, 1'b1, 1'b0, 32'h400, 32'd0, 1'b0, 1, 1'b1, 1'b1, 32'd0, "t3 out of range");
    txn(0, 1'b1, 1'b1, 32'h8, 32'hFFFFFFFF, 1'b0, 1, 1'b1, 1'b1, 32'd0, "t3 read+write");
    txn(0, 1'b1, 1'b0, 32'h8, 32'd0, 1'b0, 3, 1'b0, 1'b1, 32'h0BADF00D, "t3 0x8 intact");

    // Top word of the array
    txn(0, 1'b0, 1'b1, 32'h3FC, 32'h5A5A0001, 1'b0, 3, 1'b0, 1'b0, 32'd0, "store 0x3FC");
    txn(0, 1'b1, 1'b0, 32'h3FC, 32'd0, 1'b0, 3, 1'b0, 1'b1, 32'h5A5A0001, "load 0x3FC");

    // Inputs changed during WAIT are ignored
    txn(0, 1'b0, 1'b1, 32'h4, 32'h11111111, 1'b0, 3, 1'b0, 1'b0, 32'd0, "t6 store 0x4");
    txn(0, 1'b1, 1'b0, 32'h4, 32'd0, 1'b1, 3, 1'b0, 1'b1, 32'h11111111, "t6 load 0x4");
    repeat (6) step();

    // Zero wait states
    txn(1, 1'b0, 1'b1, 32'h0, 32'h12345678, 1'b0, 1, 1'b0, 1'b0, 32'd0, "t2 store 0x0");
    txn(1, 1'b1, 1'b0, 32'h0, 32'd0, 1'b0, 1, 1'b0, 1'b1, 32'h12345678, "t2 load 0x0");

    // Non-zero base
    txn(2, 1'b1, 1'b0, 32'h0FFC, 32'd0, 1'b0, 1, 1'b1, 1'b1, 32'd0, "t4 below base");
    txn(2, 1'b0, 1'b1, 32'h1000, 32'hA5A5A5A5, 1'b0, 3, 1'b0, 1'b0, 32'd0, "t4 store 0x1000");
    txn(2, 1'b1, 1'b0, 32'h1000, 32'd0, 1'b0, 3, 1'b0, 1'b1, 32'hA5A5A5A5, "t4 load 0x1000");
    txn(2, 1'b1, 1'b0, 32'h1400, 32'd0, 1'b0, 1, 1'b1, 1'b1, 32'd0, "t4 past end");

    // Reset during WAIT aborts the store
    txn(3, 1'b0, 1'b1, 32'h20, 32'h01020304, 1'b0, 5, 1'b0, 1'b0, 32'd0, "t5 store 0x20");
    txn(3, 1'b1, 1'b0, 32'h20, 32'd0, 1'b0, 5, 1'b0, 1'b1, 32'h01020304, "t5 load 0x20");
    abort_wr(3, 32'h20, 32'hCAFEF00D);
    txn(3, 1'b1, 1'b0, 32'h20, 32'd0, 1'b0, 5, 1'b0, 1'b1, 32'h01020304, "t5 old value");

    repeat (4) step();
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule
